// File: rtl/reset_sequencer_if.sv
// Bus between the reset sequencer and its downstream domains:
// software restart request, per-domain ready/reset and status.
interface reset_sequencer_if #(
   parameter int N_DOMAINS = 4
);
   localparam int FW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

   logic                 req_reset;
   logic [N_DOMAINS-1:0] ready_in;
   logic [N_DOMAINS-1:0] reset_out;
   logic                 done;
   logic                 timeout_err;
   logic [FW-1:0]        fault_idx;

   modport master (
      input  req_reset, ready_in,
      output reset_out, done, timeout_err, fault_idx
   );

   modport slave (
      output req_reset, ready_in,
      input  reset_out, done, timeout_err, fault_idx
   );
endinterface

// File: rtl/reset_sequencer.sv
// Holds all reset domains for a minimum width, then releases them one by one
// in index order, each after the previous domain acknowledges plus a gap.
module reset_sequencer #(
   parameter int N_DOMAINS     = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int GAP_CYCLES    = 8,
   parameter int READY_TIMEOUT = 1024
) (
   input logic               clk,
   input logic               reset,
   reset_sequencer_if.master bus
);
   localparam int IW   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES)
                         ? ((HOLD_CYCLES > READY_TIMEOUT) ? HOLD_CYCLES : READY_TIMEOUT)
                         : ((GAP_CYCLES > READY_TIMEOUT) ? GAP_CYCLES : READY_TIMEOUT);
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(READY_TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DOMAINS - 1);

   typedef enum logic [2:0] {S_HOLD, S_WAIT, S_GAP, S_DONE, S_ERROR} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [N_DOMAINS-1:0] reset_out_q, reset_out_d;
   logic                 done_q, done_d;
   logic                 timeout_err_q, timeout_err_d;
   logic [IW-1:0]        fault_idx_q, fault_idx_d;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      reset_out_d   = reset_out_q;
      done_d        = done_q;
      timeout_err_d = timeout_err_q;
      fault_idx_d   = fault_idx_q;

      unique case (state_q)
         S_HOLD: begin
            reset_out_d = '1;
            if (cnt_q == HOLD_LAST) begin
               reset_out_d[0] = 1'b0;
               idx_d          = '0;
               cnt_d          = '0;
               state_d        = S_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT: begin
            // ack wins over timeout when both land on the same edge
            if (bus.ready_in[idx_q]) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_GAP;
               end
            end else if (cnt_q == TO_LAST) begin
               reset_out_d   = '1;
               timeout_err_d = 1'b1;
               fault_idx_d   = idx_q;
               state_d       = S_ERROR;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               reset_out_d[idx_q + IW'(1)] = 1'b0;
               idx_d   = idx_q + IW'(1);
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE, S_ERROR: ;
         default: state_d = S_HOLD;
      endcase

      // restart keeps the sticky error and its index for software to read
      if (bus.req_reset) begin
         state_d     = S_HOLD;
         cnt_d       = '0;
         reset_out_d = '1;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_HOLD;
         cnt_q         <= '0;
         idx_q         <= '0;
         reset_out_q   <= '1;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         fault_idx_q   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         reset_out_q   <= reset_out_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         fault_idx_q   <= fault_idx_d;
      end
   end

   assign bus.reset_out   = reset_out_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.fault_idx   = fault_idx_q;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequenced reset controller for the LabBS hardware. After a global synchronous reset or a software request, it holds every downstream reset domain in reset for a minimum width. It then releases the domains one at a time in index order, waiting for each domain's ready acknowledgement plus a fixed gap before releasing the next. Each `reset_out[i]` drives the `reset_in` of that domain's 3-stage reset synchronizer, so every output is a glitch-free registered signal.

## Interface
- `N_DOMAINS`, 4: number of sequenced reset domains; ≥1.
- `HOLD_CYCLES`, 16: minimum cycles all outputs stay asserted; ≥1.
- `GAP_CYCLES`, 8: cycles between sampling `ready_in[i]` high and releasing domain i+1; ≥1.
- `READY_TIMEOUT`, 1024: cycles allowed for `ready_in[i]` after release of domain i; ≥1.
- `clk` in 1: single clock; everything is synchronous to it.
- `reset` in 1: synchronous, active-high reset.
- `req_reset` in 1: single-cycle software request to restart the full sequence.
- `ready_in` in N_DOMAINS: per-domain ready; the domain raises it once out of reset.
- `reset_out` in/out: out N_DOMAINS; per-domain reset, active-high, registered.
- `done` out 1: all domains released and acknowledged.
- `timeout_err` out 1: sticky; a domain failed to acknowledge.
- `fault_idx` out max(1,$clog2(N_DOMAINS)): index of the domain that timed out.

## Operation
- Reset values:
  - `reset_out` = all ones.
  - `done` = 0, `timeout_err` = 0, `fault_idx` = 0.
  - State = HOLD, counter = 0.
- States:
  - HOLD:
    - All `reset_out` high.
    - Counts HOLD_CYCLES cycles.
    - Then clears `reset_out[0]`, sets idx=0 and enters WAIT.
  - WAIT:
    - Counts cycles since the release of domain idx.
    - If `ready_in[idx]` is sampled high:
      - If idx is the last domain, enter DONE.
      - Otherwise enter GAP.
    - If READY_TIMEOUT cycles elapse without `ready_in[idx]` high, enter ERROR.
  - GAP:
    - Counts GAP_CYCLES.
    - Then clears `reset_out[idx+1]`, increments idx and returns to WAIT.
  - DONE:
    - `done`=1; all `reset_out` low.
    - Holds until `req_reset` or `reset`.
  - ERROR:
    - All `reset_out` reasserted high.
    - `timeout_err`=1 and `fault_idx`=idx.
    - Holds until `req_reset` or `reset`.
- `req_reset` in any state, including mid-sequence:
  - Next edge: all `reset_out` high, `done`=0, enter HOLD with counter cleared.
  - `timeout_err` and `fault_idx` are retained; they clear only on `reset`.
- `reset` has priority over `req_reset`.
- Released domains are never reasserted individually. `ready_in` of an already-acknowledged domain is ignored, including if it drops later.
- `ready_in` bits of unreleased domains are ignored.
- Release order is strictly 0 → N_DOMAINS-1. At most one `reset_out` bit changes per cycle, except on whole-vector reassertion.
- Counter width is sized for the largest of HOLD_CYCLES, GAP_CYCLES and READY_TIMEOUT. No wrap-around is permitted.

## Timing
- Cycle numbering: edge 1 is the first edge sampling `reset`=0 (or the edge after the `req_reset` edge).
- HOLD:
  - `reset_out` is all ones through edge HOLD_CYCLES-1.
  - `reset_out[0]` falls at edge HOLD_CYCLES.
- Release of domain i at edge r:
  - `ready_in[i]` is sampled from edge r+1 onward.
  - If it is first seen at edge t, `reset_out[i+1]` falls at edge t+GAP_CYCLES.
- Timeout: if `ready_in[i]` is low at every edge r+1 … r+READY_TIMEOUT, then at edge r+READY_TIMEOUT:
  - All `reset_out` go high.
  - `timeout_err` goes to 1 and `fault_idx` goes to i.
- Last domain: `done` rises at edge t, where t is the edge that samples the last domain's `ready_in` high.
- Total minimum latency, with ready_in tied high: HOLD_CYCLES + (N_DOMAINS-1)·(GAP_CYCLES+1) + 1 edges to `done`.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Nominal sequence, ready_in tied high (N=3, HOLD=4, GAP=2, TIMEOUT=8):
  - Deassert `reset`.
  - `reset_out` goes 111 → 110 at edge 4 → 100 at edge 7 → 000 at edge 10.
  - `done`=1 at edge 11.
- Delayed ack:
  - Raise `ready_in[0]` 5 cycles after `reset_out[0]` falls.
  - `reset_out[1]` falls exactly 2 edges after `ready_in[0]` is sampled high.
  - `timeout_err` stays 0.
- Timeout:
  - Hold `ready_in[1]` at 0.
  - Exactly 8 edges after `reset_out[1]` falls: `reset_out`=111, `timeout_err`=1, `fault_idx`=1, `done`=0, and the state stays there.
- Recovery from timeout:
  - Pulse `req_reset`, with ready_in now high.
  - The full sequence repeats with the timing of the nominal case.
  - `timeout_err` stays 1 until `reset` is pulsed; the `reset` pulse clears it to 0.
- Mid-sequence abort:
  - Pulse `req_reset` while in GAP after domain 0.
  - Next edge: `reset_out`=111; HOLD restarts with a full 4 cycles.
  - The simultaneous `reset`+`req_reset` case resets all outputs to their reset values.
- Ack ordering:
  - Raise `ready_in[2]` before domain 2 is released.
  - It has no effect: `reset_out[2]` still falls only after `ready_in[1]` is seen plus GAP.
  - Dropping `ready_in[0]` in DONE leaves `done`=1.
